emif_rr_arbiter: RTL and testbench
==================================

// Module: emif_rr_arbiter
// PURPOSE
// - Shares one Avalon-MM EMIF port (512-bit, word-addressed) between two matrix DRAM agents, masters m0 and m1.
// - Round-robin command arbitration with stall lock and write-burst lock.
// - Tag FIFO routes each returning read burst to the master that issued it.
// - Sits between the DRAM agents and the EMIF; lets two matrix jobs run concurrently.
// PARAMETERS
// DATA_WIDTH   512  data bus width
// ADDR_WIDTH   28   word address width
// BURST_WIDTH  7    burstcount width (max burst 64)
// TAG_DEPTH    16   max outstanding read bursts (power of 2)
// PORTS  (N = 0,1; one full set per master)
// clk                 in   1            clock
// reset               in   1            synchronous, active-high
// mN_address          in   ADDR_WIDTH   master command address
// mN_read / mN_write  in   1            master command strobes (never both high)
// mN_burstcount       in   BURST_WIDTH  beats in burst
// mN_writedata        in   DATA_WIDTH   write beat
// mN_waitrequest      out  1            stall to master
// mN_readdata         out  DATA_WIDTH   = emif_readdata (broadcast to both masters)
// mN_readdatavalid    out  1            returned beat belongs to N
// emif_address/read/write/burstcount/writedata  out  as above  muxed command
// emif_waitrequest    in   1            EMIF stall
// emif_readdata       in   DATA_WIDTH   EMIF read beat
// emif_readdatavalid  in   1            EMIF beat valid
// err_orphan          out  1            sticky: beat arrived with tag FIFO empty
// perf_grant0/1, perf_stall  out  32    performance counters (see CONFIGURATION)
// BEHAVIOUR
// - Command path is combinational (0-cycle): EMIF outputs = granted master's command.
//   All EMIF strobes are 0 when nothing is granted.
// - Non-granted master sees waitrequest=1. Granted master sees waitrequest=emif_waitrequest.
// - Request from N = mN_read | mN_write.
//   A read counts as a request only while the tag FIFO is not full; writes are unaffected.
// - FSM ARB: picks the sole requester. If both request, picks ~last (last = master of last accepted command).
//   - Granted command stalled (emif_waitrequest=1) -> HOLD.
//   - Accepted write with burstcount>1 -> WBURST, beats_left = burstcount-1.
//   - Any other acceptance -> stay in ARB.
// - FSM HOLD: grant frozen on owner; command must not change.
//   - On acceptance -> ARB, or -> WBURST if it is a multi-beat write.
// - FSM WBURST: grant locked to owner. Each accepted write beat decrements beats_left. Reaching 0 -> ARB.
// - last updates only on an accepted first command cycle. Reset sets last=1, so m0 wins the first tie.
// - Read acceptance pushes {id, burstcount} into the tag FIFO. burstcount 0 is illegal and is tagged as 1.
// - Return routing:
//   - mN_readdatavalid = emif_readdatavalid & (head.id==N), combinational.
//   - rcnt counts beats. On rcnt==head.burstcount-1: pop and clear rcnt.
//   - Push and pop in the same cycle are allowed; occupancy unchanged.
// - Beat arriving with the FIFO empty: forwarded to neither master; err_orphan set until reset.
// - Reset, including mid-burst: FSM->ARB, FIFO cleared, rcnt=0, err_orphan=0, counters=0.
//   All outputs derived from cleared state: strobes 0, readdatavalid 0.
// CONFIGURATION
// - ARB_PERF_EN defined:
//   - perf_grantN counts accepted commands from N (a burst counts once).
//   - perf_stall counts cycles where a request is present but nothing is accepted.
//   - All counters wrap at 2^32.
// - ARB_PERF_EN undefined: the perf ports exist and are tied to 0; no counter logic.
// TESTING
// 1. m0 read burst 4 @0x100, m1 idle
//    -> emif_read same cycle; 4 beats return, all m0_readdatavalid; m1_readdatavalid stays 0.
// 2. m0 and m1 read every cycle, no stall
//    -> grants alternate m0, m1, m0, ...; m0 granted first after reset.
// 3. m1 read stalled 3 cycles by emif_waitrequest while m0 requests
//    -> grant stays m1 (HOLD) until accepted, then m0.
// 4. m0 write burst 4 interleaved with m1 read requests
//    -> all 4 m0 beats are contiguous on EMIF before m1 is granted.
// 5. 16 outstanding reads with no returns
//    -> the 17th read is stalled while a write from the other master still passes;
//       one full burst return frees the slot.
// 6. emif_readdatavalid with empty FIFO -> err_orphan=1 and held; reset -> 0.

Source files
------------

// File: rtl/emif_rr_arbiter_if.sv
// emif_rr_arbiter_if: one Avalon-MM burst port (command + read return).
//   master modport: drives address/read/write/burstcount/writedata,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image.
// Used for both agent-side ports and the EMIF-side port of emif_rr_arbiter.
interface emif_rr_arbiter_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]  address;
  logic                   read;
  logic                   write;
  logic [BURST_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]  writedata;
  logic                   waitrequest;
  logic [DATA_WIDTH-1:0]  readdata;
  logic                   readdatavalid;

  modport master (
    output address, read, write, burstcount, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, read, write, burstcount, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/emif_rr_arbiter.sv
// emif_rr_arbiter: shares one 512-bit word-addressed Avalon-MM EMIF port
// between two matrix DRAM agents (m0, m1).
//   - Combinational command mux, round-robin on ties, grant locked while a
//     command is stalled (HOLD) and for the rest of a write burst (WBURST).
//   - Tag FIFO of {master id, burstcount} routes returning read beats.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   m0, m1            agent ports (slave modport)
//   emif              EMIF port (master modport)
//   o_err_orphan      sticky: read beat returned with no outstanding tag
//   o_perf_grant0/1   accepted commands per master (a burst counts once)
//   o_perf_stall      cycles with a request present but nothing accepted
// Build option: define ARB_PERF_EN to build the perf counters; otherwise
// the perf ports are tied to 0.
module emif_rr_arbiter #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_WIDTH = 7,
  parameter int TAG_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  emif_rr_arbiter_if.slave     m0,
  emif_rr_arbiter_if.slave     m1,
  emif_rr_arbiter_if.master    emif,
  output logic                 o_err_orphan,
  output logic [31:0]          o_perf_grant0,
  output logic [31:0]          o_perf_grant1,
  output logic [31:0]          o_perf_stall
);

  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam logic [BURST_WIDTH-1:0] BC_ONE  = BURST_WIDTH'(1);
  localparam logic [TAG_AW:0]        PTR_ONE = (TAG_AW+1)'(1);

  typedef enum logic [1:0] {S_ARB, S_HOLD, S_WBURST} state_t;
  typedef struct packed {
    logic                   id;
    logic [BURST_WIDTH-1:0] bc;
  } tag_t;

  // ---------------- per-master command view ----------------
  logic [1:0][ADDR_WIDTH-1:0]  w_m_addr;
  logic [1:0][BURST_WIDTH-1:0] w_m_bc;
  logic [1:0][DATA_WIDTH-1:0]  w_m_wd;
  logic [1:0]                  w_rd, w_wr, w_req;
  logic                        w_tag_full, w_tag_empty;

  assign w_m_addr = {m1.address,    m0.address};
  assign w_m_bc   = {m1.burstcount, m0.burstcount};
  assign w_m_wd   = {m1.writedata,  m0.writedata};
  assign w_rd     = {m1.read,  m0.read};
  assign w_wr     = {m1.write, m0.write};
  // Reads are held off while every tag slot is in use; writes need no tag.
  assign w_req    = (w_rd & {2{~w_tag_full}}) | w_wr;

  // ---------------- grant ----------------
  state_t                 r_state, w_state_nxt;
  logic                   r_owner, w_owner_nxt;
  logic                   r_last;
  logic [BURST_WIDTH-1:0] r_beats, w_beats_nxt;
  logic                   w_gnt, w_gnt_vld, w_accept, w_first, w_multi;

  always_comb begin
    w_gnt     = r_owner;
    w_gnt_vld = 1'b0;
    case (r_state)
      S_ARB: begin
        w_gnt_vld = |w_req;
        if (&w_req) w_gnt = ~r_last;
        else        w_gnt = w_req[1];
      end
      default: w_gnt_vld = w_req[r_owner];  // HOLD / WBURST: locked to owner
    endcase
  end

  assign w_accept = w_gnt_vld & ~emif.waitrequest;
  // First cycle of a command (burst beats after the first are not "first").
  assign w_first  = w_accept & (r_state != S_WBURST);
  assign w_multi  = w_wr[w_gnt] & (w_m_bc[w_gnt] > BC_ONE);

  assign emif.address    = w_m_addr[w_gnt];
  assign emif.burstcount = w_m_bc[w_gnt];
  assign emif.writedata  = w_m_wd[w_gnt];
  assign emif.read       = w_gnt_vld & w_rd[w_gnt];
  assign emif.write      = w_gnt_vld & w_wr[w_gnt];

  assign m0.waitrequest  = ~(w_gnt_vld & ~w_gnt) | emif.waitrequest;
  assign m1.waitrequest  = ~(w_gnt_vld &  w_gnt) | emif.waitrequest;

  // ---------------- FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beats_nxt = r_beats;
    case (r_state)
      S_ARB: if (w_gnt_vld) begin
        w_owner_nxt = w_gnt;
        if (emif.waitrequest) begin
          w_state_nxt = S_HOLD;
        end else if (w_multi) begin
          w_state_nxt = S_WBURST;
          w_beats_nxt = w_m_bc[w_gnt] - BC_ONE;
        end
      end
      S_HOLD: if (w_accept) begin
        if (w_multi) begin
          w_state_nxt = S_WBURST;
          w_beats_nxt = w_m_bc[w_gnt] - BC_ONE;
        end else begin
          w_state_nxt = S_ARB;
        end
      end
      S_WBURST: if (w_accept && w_wr[r_owner]) begin
        w_beats_nxt = r_beats - BC_ONE;
        if (r_beats == BC_ONE) w_state_nxt = S_ARB;
      end
      default: w_state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ARB;
      r_owner <= 1'b0;
      r_beats <= '0;
      r_last  <= 1'b1;   // m0 wins the first tie
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beats <= w_beats_nxt;
      if (w_first) r_last <= w_gnt;
    end
  end

  // ---------------- tag FIFO / return routing ----------------
  tag_t                   r_tag_mem [TAG_DEPTH];
  logic [TAG_AW:0]        r_wr_ptr, r_rd_ptr;
  logic [BURST_WIDTH-1:0] r_rcnt;
  logic                   r_err_orphan;
  tag_t                   w_head, w_push_tag;
  logic                   w_push, w_beat, w_pop;

  assign w_tag_empty = (r_wr_ptr == r_rd_ptr);
  assign w_tag_full  = (r_wr_ptr[TAG_AW] != r_rd_ptr[TAG_AW]) &&
                       (r_wr_ptr[TAG_AW-1:0] == r_rd_ptr[TAG_AW-1:0]);
  assign w_head      = r_tag_mem[r_rd_ptr[TAG_AW-1:0]];

  assign w_push        = w_accept & emif.read;
  assign w_push_tag.id = w_gnt;
  // A zero burstcount is illegal; track it as a single beat.
  assign w_push_tag.bc = (emif.burstcount == '0) ? BC_ONE : emif.burstcount;

  assign w_beat = emif.readdatavalid & ~w_tag_empty;
  assign w_pop  = w_beat & (r_rcnt == w_head.bc - BC_ONE);

  assign m0.readdata      = emif.readdata;
  assign m1.readdata      = emif.readdata;
  assign m0.readdatavalid = w_beat & ~w_head.id;
  assign m1.readdatavalid = w_beat &  w_head.id;
  assign o_err_orphan     = r_err_orphan;

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr[TAG_AW-1:0]] <= w_push_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rcnt       <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_rcnt   <= '0;
      end else if (w_beat) begin
        r_rcnt   <= r_rcnt + BC_ONE;
      end
      if (emif.readdatavalid && w_tag_empty) r_err_orphan <= 1'b1;
    end
  end

  // ---------------- performance counters ----------------
`ifdef ARB_PERF_EN
  logic [31:0] r_perf_g0, r_perf_g1, r_perf_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_g0 <= '0;
      r_perf_g1 <= '0;
      r_perf_st <= '0;
    end else begin
      if (w_first && !w_gnt) r_perf_g0 <= r_perf_g0 + 32'd1;
      if (w_first &&  w_gnt) r_perf_g1 <= r_perf_g1 + 32'd1;
      if ((|w_req) && !w_accept) r_perf_st <= r_perf_st + 32'd1;
    end
  end

  assign o_perf_grant0 = r_perf_g0;
  assign o_perf_grant1 = r_perf_g1;
  assign o_perf_stall  = r_perf_st;
`else
  assign o_perf_grant0 = '0;
  assign o_perf_grant1 = '0;
  assign o_perf_stall  = '0;
`endif

endmodule

// File: tb/tb_emif_rr_arbiter.sv
// Self-checking bench for emif_rr_arbiter. Expected read-return owners are
// queued when a read is issued and consumed beat by beat on return.
module tb_emif_rr_arbiter;
  localparam int DW = 512, AW = 28, BW = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_orphan;
  logic [31:0] pg0, pg1, pst;

  emif_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) m0_if ();
  emif_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) m1_if ();
  emif_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) emif_if ();

  emif_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .TAG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .emif(emif_if),
    .o_err_orphan(err_orphan), .o_perf_grant0(pg0), .o_perf_grant1(pg1), .o_perf_stall(pst)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int sb_id[$];
  int sb_left[$];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_m(input int n, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] wd);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.burstcount = bc; m0_if.writedata = wd;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.burstcount = bc; m1_if.writedata = wd;
    end
  endtask

  task automatic idle();
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    emif_if.waitrequest = 1'b0; emif_if.readdatavalid = 1'b0; emif_if.readdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb_id.delete(); sb_left.delete();
  endtask

  task automatic push_exp(input int id, input int beats);
    sb_id.push_back(id); sb_left.push_back(beats);
  endtask

  // Drive n return beats; each beat must go to the queue head's owner.
  task automatic return_beats(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      int eid;
      d = {16{$urandom()}};
      emif_if.readdatavalid = 1'b1; emif_if.readdata = d;
      @(negedge clk);
      eid = (sb_id.size() > 0) ? sb_id[0] : -1;
      n_checks++; if (m0_if.readdatavalid !== (eid == 0)) begin n_errors++; $display("FAIL rdv0 beat %0d: got %b exp %b", i, m0_if.readdatavalid, eid == 0); end
      n_checks++; if (m1_if.readdatavalid !== (eid == 1)) begin n_errors++; $display("FAIL rdv1 beat %0d: got %b exp %b", i, m1_if.readdatavalid, eid == 1); end
      n_checks++; if (m0_if.readdata !== d || m1_if.readdata !== d) begin n_errors++; $display("FAIL readdata beat %0d: got %0h exp %0h", i, m0_if.readdata, d); end
      if (eid >= 0) begin
        sb_left[0]--;
        if (sb_left[0] == 0) begin void'(sb_id.pop_front()); void'(sb_left.pop_front()); end
      end
      cyc();
    end
    emif_if.readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    emif_if.waitrequest = 1'b0; emif_if.readdatavalid = 1'b1; emif_if.readdata = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL reset_rdv: got %b%b exp 00", m1_if.readdatavalid, m0_if.readdatavalid); end
    n_checks++; if (emif_if.read !== 1'b0 || emif_if.write !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got r%b w%b exp 0 0", emif_if.read, emif_if.write); end
    n_checks++; if (err_orphan !== 1'b0) begin n_errors++; $display("FAIL reset_orphan: got %b exp 0", err_orphan); end
    emif_if.readdatavalid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (pg0 !== 32'd0 || pg1 !== 32'd0 || pst !== 32'd0) begin n_errors++; $display("FAIL reset_perf: got %0d %0d %0d exp 0 0 0", pg0, pg1, pst); end
    n_checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wait: got %b%b exp 11", m1_if.waitrequest, m0_if.waitrequest); end
    cyc();
  endtask

  task automatic test_single_read();
    do_reset();
    set_m(0, 1, 0, 28'h100, 7'd4, '0);
    @(negedge clk);
    n_checks++; if (emif_if.read !== 1'b1 || emif_if.address !== 28'h100 || emif_if.burstcount !== 7'd4) begin n_errors++; $display("FAIL single_cmd: got r%b a%0h bc%0d exp r1 a100 bc4", emif_if.read, emif_if.address, emif_if.burstcount); end
    n_checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL single_wait: got %b%b exp 10", m1_if.waitrequest, m0_if.waitrequest); end
    push_exp(0, 4);
    cyc(); idle();
    return_beats(4);
    // burstcount 0 is tracked as one beat; the following beat is an orphan
    set_m(1, 1, 0, 28'h180, 7'd0, '0);
    @(negedge clk);
    n_checks++; if (m1_if.waitrequest !== 1'b0) begin n_errors++; $display("FAIL bc0_wait: got %b exp 0", m1_if.waitrequest); end
    push_exp(1, 1);
    cyc(); idle();
    return_beats(2);
    @(negedge clk);
    n_checks++; if (err_orphan !== 1'b1) begin n_errors++; $display("FAIL bc0_orphan: got %b exp 1", err_orphan); end
    cyc();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int e;
      e = i % 2;
      set_m(0, 1, 0, 28'h10 + AW'(i), 7'd1, '0);
      set_m(1, 1, 0, 28'h20 + AW'(i), 7'd1, '0);
      @(negedge clk);
      n_checks++; if (m0_if.waitrequest !== (e != 0) || m1_if.waitrequest !== (e != 1)) begin n_errors++; $display("FAIL alt_grant %0d: got w1w0=%b%b exp owner m%0d", i, m1_if.waitrequest, m0_if.waitrequest, e); end
      n_checks++; if (emif_if.address !== ((e == 1) ? 28'h20 + AW'(i) : 28'h10 + AW'(i))) begin n_errors++; $display("FAIL alt_addr %0d: got %0h", i, emif_if.address); end
      push_exp(e, 1);
      cyc();
    end
    idle();
`ifdef ARB_PERF_EN
    @(negedge clk);
    n_checks++; if (pg0 !== 32'd3 || pg1 !== 32'd3 || pst !== 32'd0) begin n_errors++; $display("FAIL alt_perf: got %0d %0d %0d exp 3 3 0", pg0, pg1, pst); end
    cyc();
`endif
    return_beats(6);
  endtask

  task automatic test_hold();
    do_reset();
    emif_if.waitrequest = 1'b1;
    set_m(1, 1, 0, 28'h30, 7'd1, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (emif_if.read !== 1'b1 || emif_if.address !== 28'h30 || m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL hold %0d: got r%b a%0h w1w0=%b%b exp r1 a30 11", i, emif_if.read, emif_if.address, m1_if.waitrequest, m0_if.waitrequest); end
      cyc();
      set_m(0, 1, 0, 28'h40, 7'd1, '0);
    end
    emif_if.waitrequest = 1'b0;
    @(negedge clk);
    n_checks++; if (m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b1 || emif_if.address !== 28'h30) begin n_errors++; $display("FAIL hold_accept: got w1w0=%b%b a%0h exp 01 a30", m1_if.waitrequest, m0_if.waitrequest, emif_if.address); end
    push_exp(1, 1);
    cyc();
    set_m(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    n_checks++; if (m0_if.waitrequest !== 1'b0 || emif_if.address !== 28'h40) begin n_errors++; $display("FAIL hold_next: got w0=%b a%0h exp 0 a40", m0_if.waitrequest, emif_if.address); end
    push_exp(0, 1);
    cyc(); idle();
`ifdef ARB_PERF_EN
    @(negedge clk);
    n_checks++; if (pg0 !== 32'd1 || pg1 !== 32'd1 || pst !== 32'd3) begin n_errors++; $display("FAIL hold_perf: got %0d %0d %0d exp 1 1 3", pg0, pg1, pst); end
    cyc();
`endif
    return_beats(2);
  endtask

  task automatic test_wburst();
    logic [DW-1:0] wd [4];
    do_reset();
    for (int b = 0; b < 4; b++) wd[b] = {16{$urandom()}};
    set_m(0, 0, 1, 28'h50, 7'd4, wd[0]);
    set_m(1, 1, 0, 28'h60, 7'd1, '0);
    for (int b = 0; b < 4; b++) begin
      m0_if.writedata = wd[b];
      if (b == 2) begin
        emif_if.waitrequest = 1'b1;
        @(negedge clk);
        n_checks++; if (emif_if.write !== 1'b1 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL wb_stall: got w%b wait1=%b exp 1 1", emif_if.write, m1_if.waitrequest); end
        cyc();
        emif_if.waitrequest = 1'b0;
      end
      @(negedge clk);
      n_checks++; if (emif_if.write !== 1'b1 || emif_if.writedata !== wd[b] || m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin n_errors++; $display("FAIL wb_beat %0d: got w%b w1w0=%b%b data %0h", b, emif_if.write, m1_if.waitrequest, m0_if.waitrequest, emif_if.writedata); end
      cyc();
    end
    set_m(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    n_checks++; if (m1_if.waitrequest !== 1'b0 || emif_if.read !== 1'b1 || emif_if.address !== 28'h60) begin n_errors++; $display("FAIL wb_after: got wait1=%b r%b a%0h exp 0 1 a60", m1_if.waitrequest, emif_if.read, emif_if.address); end
    push_exp(1, 1);
    cyc(); idle();
    return_beats(1);
  endtask

  task automatic test_tag_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_m(0, 1, 0, 28'h200 + AW'(i), 7'd2, '0);
      @(negedge clk);
      n_checks++; if (m0_if.waitrequest !== 1'b0) begin n_errors++; $display("FAIL full_fill %0d: got wait0=%b exp 0", i, m0_if.waitrequest); end
      push_exp(0, 2);
      cyc();
    end
    set_m(0, 1, 0, 28'h300, 7'd2, '0);
    set_m(1, 0, 1, 28'h400, 7'd1, {16{32'hA5A5_5A5A}});
    @(negedge clk);
    n_checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b0 || emif_if.write !== 1'b1 || emif_if.read !== 1'b0 || emif_if.address !== 28'h400) begin n_errors++; $display("FAIL full_write: got w1w0=%b%b r%b w%b a%0h exp 01 r0 w1 a400", m1_if.waitrequest, m0_if.waitrequest, emif_if.read, emif_if.write, emif_if.address); end
    cyc();
    set_m(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    n_checks++; if (m0_if.waitrequest !== 1'b1 || emif_if.read !== 1'b0) begin n_errors++; $display("FAIL full_block: got wait0=%b r%b exp 1 0", m0_if.waitrequest, emif_if.read); end
    cyc();
    return_beats(2);
    @(negedge clk);
    n_checks++; if (m0_if.waitrequest !== 1'b0 || emif_if.read !== 1'b1 || emif_if.address !== 28'h300) begin n_errors++; $display("FAIL full_free: got wait0=%b r%b a%0h exp 0 1 a300", m0_if.waitrequest, emif_if.read, emif_if.address); end
    push_exp(0, 2);
    cyc(); idle();
    return_beats(32);
  endtask

  task automatic test_orphan_reset();
    do_reset();
    emif_if.readdatavalid = 1'b1;
    @(negedge clk);
    n_checks++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL orphan_fwd: got %b%b exp 00", m1_if.readdatavalid, m0_if.readdatavalid); end
    cyc();
    emif_if.readdatavalid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    n_checks++; if (err_orphan !== 1'b1) begin n_errors++; $display("FAIL orphan_sticky: got %b exp 1", err_orphan); end
    // reset in the middle of a write burst
    set_m(0, 0, 1, 28'h70, 7'd4, '1);
    cyc(); cyc();
    reset = 1'b1; idle();
    cyc();
    @(negedge clk);
    n_checks++; if (err_orphan !== 1'b0 || emif_if.write !== 1'b0 || emif_if.read !== 1'b0) begin n_errors++; $display("FAIL midreset: got err%b w%b r%b exp 0 0 0", err_orphan, emif_if.write, emif_if.read); end
    cyc();
    reset = 1'b0;
    set_m(1, 1, 0, 28'h80, 7'd1, '0);
    @(negedge clk);
    n_checks++; if (m1_if.waitrequest !== 1'b0 || emif_if.read !== 1'b1 || emif_if.address !== 28'h80) begin n_errors++; $display("FAIL midreset_grant: got wait1=%b r%b a%0h exp 0 1 a80", m1_if.waitrequest, emif_if.read, emif_if.address); end
    push_exp(1, 1);
    cyc(); idle();
    return_beats(1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_hold();
    test_wburst();
    test_tag_full();
    test_orphan_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
